// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing generator.
// A clock-enable divider produces one pixel tick every CLK_DIV clocks. The
// x/y raster counters advance on each tick and are presented directly as
// pix_x/pix_y/pix_de. Colour, HS and VS are registered on the tick, so the
// pins lag the presented coordinate by exactly one pixel tick.
// After reset release or an en rise there is one arming cycle. frame_start
// then marks the first clock of the (0,0) pixel. That pixel is held for a
// full CLK_DIV clocks, the same as after a frame wrap.
module vga_timing_gen #(
    parameter int CLK_DIV = 4,
    parameter int H_ACT   = 640,
    parameter int H_FP    = 16,
    parameter int H_SYNC  = 96,
    parameter int H_BP    = 48,
    parameter int V_ACT   = 480,
    parameter int V_FP    = 10,
    parameter int V_SYNC  = 2,
    parameter int V_BP    = 33,
    parameter int HS_POL  = 0,
    parameter int VS_POL  = 0,
    parameter int CW      = 4,
    parameter int XW      = 10,
    parameter int YW      = 10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [3*CW-1:0] rgb_in,
    output logic [XW-1:0]   pix_x,
    output logic [YW-1:0]   pix_y,
    output logic            pix_de,
    output logic            pix_tick,
    output logic            frame_start,
    output logic            HS,
    output logic            VS,
    output logic [CW-1:0]   R,
    output logic [CW-1:0]   G,
    output logic [CW-1:0]   B
);

    localparam int H_TOTAL = H_ACT + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACT + V_FP + V_SYNC + V_BP;
    localparam int HS_BEG  = H_ACT + H_FP;
    localparam int HS_END  = H_ACT + H_FP + H_SYNC;
    localparam int VS_BEG  = V_ACT + V_FP;
    localparam int VS_END  = V_ACT + V_FP + V_SYNC;
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    // Active and idle levels of the sync outputs.
    localparam logic HS_ON  = (HS_POL != 0) ? 1'b1 : 1'b0;
    localparam logic VS_ON  = (VS_POL != 0) ? 1'b1 : 1'b0;
    localparam logic HS_OFF = ~HS_ON;
    localparam logic VS_OFF = ~VS_ON;

    // Raster state.
    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic          run_q, run_d;   // raster is scanning (armed)
    logic          fs_q, fs_d;     // frame_start strobe

    // Pixel pipeline stage.
    logic          hs_q, hs_d;
    logic          vs_q, vs_d;
    logic [CW-1:0] r_q, r_d;
    logic [CW-1:0] g_q, g_d;
    logic [CW-1:0] b_q, b_d;

    logic tick_s;
    logic de_s;
    logic x_last_s;
    logic y_last_s;
    logic hs_win_s;
    logic vs_win_s;

    // Decode the tick, the wrap points, the active area and the sync windows.
    always_comb begin
        tick_s   = en & run_q & (int'(div_cnt_q) == CLK_DIV - 1);
        x_last_s = (int'(x_q) == H_TOTAL - 1);
        y_last_s = (int'(y_q) == V_TOTAL - 1);
        de_s     = en & run_q & (int'(x_q) < H_ACT) & (int'(y_q) < V_ACT);
        hs_win_s = (int'(x_q) >= HS_BEG) & (int'(x_q) < HS_END);
        vs_win_s = (int'(y_q) >= VS_BEG) & (int'(y_q) < VS_END);
    end

    // Next-state for the divider, the raster counters and frame_start.
    // A low en wins over everything else; a wrap only happens while running.
    always_comb begin
        div_cnt_d = div_cnt_q;
        x_d       = x_q;
        y_d       = y_q;
        run_d     = run_q;
        fs_d      = 1'b0;
        if (!en) begin
            div_cnt_d = {DW{1'b0}};
            x_d       = {XW{1'b0}};
            y_d       = {YW{1'b0}};
            run_d     = 1'b0;
        end else if (!run_q) begin
            // Arming cycle: (0,0) starts with a fresh divider next clock.
            div_cnt_d = {DW{1'b0}};
            x_d       = {XW{1'b0}};
            y_d       = {YW{1'b0}};
            run_d     = 1'b1;
            fs_d      = 1'b1;
        end else if (tick_s) begin
            div_cnt_d = {DW{1'b0}};
            if (x_last_s) begin
                x_d = {XW{1'b0}};
                if (y_last_s) begin
                    y_d  = {YW{1'b0}};
                    fs_d = 1'b1;
                end else begin
                    y_d = y_q + YW'(1);
                end
            end else begin
                x_d = x_q + XW'(1);
            end
        end else begin
            div_cnt_d = div_cnt_q + DW'(1);
        end
    end

    // Next-state for the one-tick colour/sync pipeline stage.
    always_comb begin
        hs_d = hs_q;
        vs_d = vs_q;
        r_d  = r_q;
        g_d  = g_q;
        b_d  = b_q;
        if (!en || !run_q) begin
            hs_d = HS_OFF;
            vs_d = VS_OFF;
            r_d  = {CW{1'b0}};
            g_d  = {CW{1'b0}};
            b_d  = {CW{1'b0}};
        end else if (tick_s) begin
            hs_d = hs_win_s ? HS_ON : HS_OFF;
            vs_d = vs_win_s ? VS_ON : VS_OFF;
            if (de_s) begin
                r_d = rgb_in[3*CW-1 -: CW];
                g_d = rgb_in[2*CW-1 -: CW];
                b_d = rgb_in[CW-1:0];
            end else begin
                r_d = {CW{1'b0}};
                g_d = {CW{1'b0}};
                b_d = {CW{1'b0}};
            end
        end else begin
            hs_d = hs_q;
            vs_d = vs_q;
        end
    end

    // State registers with asynchronous reset to the idle raster.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_q <= {DW{1'b0}};
            x_q       <= {XW{1'b0}};
            y_q       <= {YW{1'b0}};
            run_q     <= 1'b0;
            fs_q      <= 1'b0;
            hs_q      <= HS_OFF;
            vs_q      <= VS_OFF;
            r_q       <= {CW{1'b0}};
            g_q       <= {CW{1'b0}};
            b_q       <= {CW{1'b0}};
        end else begin
            div_cnt_q <= div_cnt_d;
            x_q       <= x_d;
            y_q       <= y_d;
            run_q     <= run_d;
            fs_q      <= fs_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            r_q       <= r_d;
            g_q       <= g_d;
            b_q       <= b_d;
        end
    end

    assign pix_x       = x_q;
    assign pix_y       = y_q;
    assign pix_de      = de_s;
    assign pix_tick    = tick_s;
    assign frame_start = fs_q;
    assign HS          = hs_q;
    assign VS          = vs_q;
    assign R           = r_q;
    assign G           = g_q;
    assign B           = b_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on a tiny raster.
// The raster is 14 x 8 with CLK_DIV=2 and HS active-high.
// HS is active for x in 10..12 and VS is active-low for y in 5..6.
// One frame is 14*8*2 = 224 clocks.
module tb_vga_timing_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [11:0] rgb_in;
    logic [4:0]  pix_x;
    logic [3:0]  pix_y;
    logic        pix_de, pix_tick, frame_start, HS, VS;
    logic [3:0]  R, G, B;

    vga_timing_gen #(
        .CLK_DIV(2), .H_ACT(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
        .V_ACT(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1), .VS_POL(0), .CW(4), .XW(5), .YW(4)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .rgb_in(rgb_in),
        .pix_x(pix_x), .pix_y(pix_y), .pix_de(pix_de), .pix_tick(pix_tick),
        .frame_start(frame_start), .HS(HS), .VS(VS), .R(R), .G(G), .B(B)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  x;
        logic [3:0]  y;
        logic        de;
        logic        hs;
        logic        vs;
        logic [11:0] rgb;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    exp_t mon_a;
    int   checks   = 0;
    int   failures = 0;
    logic mon_en   = 1'b0;
    int   fs_count = 0;
    int   fs_cyc   = 0;
    logic fs_armed = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: every pixel tick the DUT presents one pixel; pop and compare.
    always @(negedge clk) begin
        if (mon_en && pix_tick === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_underflow tick with no expected pixel x=%0d y=%0d", pix_x, pix_y);
            end else begin
                mon_e = sb_q.pop_front();
                mon_a = {pix_x, pix_y, pix_de, HS, VS, R, G, B};
                checks++;
                if (mon_a !== mon_e) begin
                    failures++;
                    $display("FAIL sb_pixel actual x=%0d y=%0d de=%b hs=%b vs=%b rgb=%h expected x=%0d y=%0d de=%b hs=%b vs=%b rgb=%h",
                             mon_a.x, mon_a.y, mon_a.de, mon_a.hs, mon_a.vs, mon_a.rgb,
                             mon_e.x, mon_e.y, mon_e.de, mon_e.hs, mon_e.vs, mon_e.rgb);
                end
            end
        end
    end

    // frame_start monitor: counts pulses and checks the period of an uninterrupted frame.
    always @(negedge clk) begin
        if (frame_start === 1'b1) fs_count++;
        if (rst !== 1'b0 || en !== 1'b1) begin
            fs_armed = 1'b0;
            fs_cyc   = 0;
        end else begin
            fs_cyc++;
            if (frame_start === 1'b1) begin
                if (fs_armed) chk("frame_period_clk", fs_cyc, 224);
                fs_armed = 1'b1;
                fs_cyc   = 0;
            end
        end
    end

    function automatic logic [11:0] pat(input int k, input logic de);
        logic [11:0] v;
        if (!de) return 12'hFFF;          // must be blanked by the DUT
        if (k % 3 == 0) return 12'hF0A;
        v = 12'(k * 291) ^ 12'h0A5;
        return v;
    endfunction

    // Stimulus after a restart: wait for frame_start, then drive n pixels and
    // push the pixel presented plus the pins expected (previous pixel's stage).
    task automatic run_ticks(input int n);
        exp_t        e;
        logic        prev_hs, prev_vs, de;
        logic [11:0] prev_rgb, c;
        int          x, y, w;
        w = 0;
        @(negedge clk);
        while (frame_start !== 1'b1 && w < 8) begin
            @(negedge clk);
            w++;
        end
        chk("restart_frame_start", frame_start, 1);
        if (frame_start !== 1'b1) return;
        prev_hs  = 1'b0;
        prev_vs  = 1'b1;
        prev_rgb = 12'h000;
        mon_en   = 1'b1;
        for (int k = 0; k < n; k++) begin
            x  = k % 14;
            y  = (k / 14) % 8;
            de = (x < 8) && (y < 4);
            c  = pat(k, de);
            e.x   = 5'(x);
            e.y   = 4'(y);
            e.de  = de;
            e.hs  = prev_hs;
            e.vs  = prev_vs;
            e.rgb = prev_rgb;
            sb_q.push_back(e);
            rgb_in   = c;
            prev_hs  = (x >= 10) && (x < 13);
            prev_vs  = !((y >= 5) && (y < 7));
            prev_rgb = de ? c : 12'h000;
            @(negedge clk);
            @(negedge clk);
        end
        mon_en = 1'b0;
        chk("sb_drained", sb_q.size(), 0);
    endtask

    initial begin
        int w;
        rst    = 1'b1;
        en     = 1'b1;
        rgb_in = 12'h000;
        repeat (3) @(negedge clk);
        chk("rst_x", pix_x, 0);
        chk("rst_y", pix_y, 0);
        chk("rst_hs", HS, 0);
        chk("rst_vs", VS, 1);
        chk("rst_rgb", {R, G, B}, 12'h000);
        chk("rst_tick", pix_tick, 0);
        chk("rst_frame_start", frame_start, 0);
        chk("rst_de", pix_de, 0);
        rst = 1'b0;

        // Full frame plus a wrap into the next frame.
        run_ticks(130);

        // Asynchronous reset in the middle of line 5, inside both sync windows.
        w = 0;
        while (!(pix_x == 5'd11 && pix_y == 4'd5) && w < 600) begin
            @(negedge clk);
            w++;
        end
        chk("reach_x11_y5", {pix_x, pix_y}, {5'd11, 4'd5});
        chk("pre_rst_hs", HS, 1);
        chk("pre_rst_vs", VS, 0);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_x", pix_x, 0);
        chk("mid_rst_y", pix_y, 0);
        chk("mid_rst_hs", HS, 0);
        chk("mid_rst_vs", VS, 1);
        chk("mid_rst_rgb", {R, G, B}, 12'h000);
        chk("mid_rst_tick", pix_tick, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        run_ticks(40);
        rgb_in = 12'h5C3;

        // Drop en in the middle of active line 3.
        w = 0;
        while (!(pix_x == 5'd5 && pix_y == 4'd3) && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk("reach_x5_y3", {pix_x, pix_y}, {5'd5, 4'd3});
        chk("pre_en_rgb", {R, G, B}, 12'h5C3);
        chk("pre_en_de", pix_de, 1);
        en = 1'b0;
        @(negedge clk);
        chk("en_low_x", pix_x, 0);
        chk("en_low_y", pix_y, 0);
        chk("en_low_tick", pix_tick, 0);
        chk("en_low_de", pix_de, 0);
        chk("en_low_hs", HS, 0);
        chk("en_low_vs", VS, 1);
        chk("en_low_rgb", {R, G, B}, 12'h000);
        chk("en_low_frame_start", frame_start, 0);
        repeat (19) @(negedge clk);
        chk("en_hold_x", pix_x, 0);
        chk("en_hold_y", pix_y, 0);
        chk("en_hold_tick", pix_tick, 0);
        en = 1'b1;

        run_ticks(30);

        // Pulses: first start, one frame wrap, restart after rst, restart after en.
        chk("frame_start_count", fs_count, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
